// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - shared types for the LRU tick table
package lru_pkg;

  typedef enum logic [1:0] {
    OP_TOUCH = 2'd0,
    OP_FILL  = 2'd1,
    OP_INVAL = 2'd2
  } lru_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_NORM = 1'b1
  } state_t;

  // Index 0 is unused, so the index must be able to hold the value num_lines itself.
  function automatic int lru_idx_width(input int num_lines);
    return $clog2(num_lines + 1);
  endfunction

  localparam int LRU_DEF_LINES     = 32;
  localparam int LRU_DEF_IDX_WIDTH = lru_idx_width(LRU_DEF_LINES);

endpackage

// File: rtl/lru_tick_halve.sv
// rtl/lru_tick_halve.sv - zero-preserving halve of one tick with a floor of 1
module lru_tick_halve #(
  parameter int TICK_WIDTH = 32
) (
  input  logic [TICK_WIDTH-1:0] tick_in,
  output logic [TICK_WIDTH-1:0] tick_out
);

  always_comb begin
    tick_out = tick_in >> 1;
    if (tick_in == '0) begin
      tick_out = '0;
    end else if ((tick_in >> 1) == '0) begin
      tick_out = TICK_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lru_tick_table.sv
// rtl/lru_tick_table.sv - per-set LRU tick store with counter normalisation pass
// Optional LRU_STATS_EN adds saturating hit/fill/normalisation counters.
module lru_tick_table
  import lru_pkg::*;
#(
  parameter int                    NUM_LINES  = LRU_DEF_LINES,
  parameter int                    IDX_WIDTH  = LRU_DEF_IDX_WIDTH,
  parameter int                    TICK_WIDTH = 32,
  parameter logic [TICK_WIDTH-1:0] TICK_MAX   = {TICK_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  output logic [TICK_WIDTH-1:0] tick [1:NUM_LINES],
  output logic [TICK_WIDTH-1:0] now,
  output logic                  normalizing
`ifdef LRU_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_fills,
  output logic [31:0]           stat_norms
`endif
);

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_LINES);
  localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0] TICK_ONE = TICK_WIDTH'(1);

  state_t                 state;
  state_t                 state_nx;
  logic [IDX_WIDTH-1:0]   ptr;
  logic                   accept;
  logic                   idx_ok;
  logic                   is_touch;
  logic                   is_fill;
  logic                   is_stamp;
  logic                   is_inval;
  logic                   trigger;
  logic                   norm_last;
  logic [TICK_WIDTH-1:0]  now_inc;
  logic [TICK_WIDTH-1:0]  norm_in;
  logic [TICK_WIDTH-1:0]  norm_out;

  assign req_ready   = (state == S_IDLE);
  assign normalizing = (state == S_NORM);

  assign accept   = req_valid && req_ready;
  assign idx_ok   = (req_idx != '0) && (req_idx <= LAST_IDX);
  assign is_touch = accept && idx_ok && (req_op == OP_TOUCH);
  assign is_fill  = accept && idx_ok && (req_op == OP_FILL);
  assign is_stamp = is_touch || is_fill;
  assign is_inval = accept && idx_ok && (req_op == OP_INVAL);
  assign now_inc  = now + TICK_ONE;

  // Fire one step early so the counter itself never reaches TICK_MAX.
  assign trigger   = is_stamp && ((now_inc + TICK_ONE) >= TICK_MAX);
  assign norm_last = normalizing && (ptr == LAST_IDX);

  assign norm_in = tick[ptr];

  lru_tick_halve #(
    .TICK_WIDTH (TICK_WIDTH)
  ) u_halve (
    .tick_in  (norm_in),
    .tick_out (norm_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (trigger)   state_nx = S_NORM;
      S_NORM: if (norm_last) state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      now   <= TICK_ONE;
      ptr   <= IDX_ONE;
      for (int i = 1; i <= NUM_LINES; i++) begin
        tick[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (normalizing) begin
        tick[ptr] <= norm_out;
        if (norm_last) begin
          now <= (now >> 1) + TICK_ONE;
          ptr <= IDX_ONE;
        end else begin
          ptr <= ptr + IDX_ONE;
        end
      end else if (is_stamp) begin
        tick[req_idx] <= now;
        now           <= now_inc;
      end else if (is_inval) begin
        tick[req_idx] <= '0;
      end
    end
  end

`ifdef LRU_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_hits  <= '0;
      stat_fills <= '0;
      stat_norms <= '0;
    end else begin
      if (is_touch && (stat_hits != '1))   stat_hits  <= stat_hits + 32'd1;
      if (is_fill && (stat_fills != '1))   stat_fills <= stat_fills + 32'd1;
      if (norm_last && (stat_norms != '1)) stat_norms <= stat_norms + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lru_tick_table.md
Name: lru_tick_table

Overview:
Per-set LRU timestamp store for the cache.
- Holds one tick per line and a monotonically increasing access counter.
- Stamps a line's tick on hit/fill and zeroes it on invalidate.
- Drives the tick array straight into the downstream min-tick victim selector; the smallest tick marks the LRU line.
- When the counter reaches its ceiling, runs a multi-cycle normalisation pass so ticks never overflow.

Parameters:
NUM_LINES, 32, number of cache lines tracked; tick array indexed 1..NUM_LINES.
IDX_WIDTH, 6, width of line index; must hold NUM_LINES.
TICK_WIDTH, 32, width of each tick and of the counter.
TICK_MAX, 2**TICK_WIDTH-1, counter value that triggers normalisation; benches set it small.

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  synchronous, active-low reset.
req_valid  in  1  access request valid.
req_ready  out  1  block can accept a request this cycle.
req_op  in  2  lru_op_t: OP_TOUCH=0, OP_FILL=1, OP_INVAL=2, 3 reserved (treated as no-op).
req_idx  in  IDX_WIDTH  target line, legal range 1..NUM_LINES.
tick  out  TICK_WIDTH x [1:NUM_LINES]  registered per-line ticks, to the victim selector.
now  out  TICK_WIDTH  current counter value.
normalizing  out  1  high while in the S_NORM state.

Behaviour:
- Reset: all tick[i]=0, now=1, state S_IDLE, req_ready=1, normaliser pointer=1. Reset asserted in S_NORM aborts the pass and restores the same values.
- Accept rule: a request is accepted when req_valid && req_ready; there is no request buffering. req_ready is combinational: 1 in S_IDLE, 0 in S_NORM.
- OP_TOUCH and OP_FILL: tick[req_idx] <= now; now <= now+1. Visible on outputs the next cycle.
- OP_INVAL: tick[req_idx] <= 0; now unchanged.
- Illegal request: if req_idx is 0 or >NUM_LINES, or the op is reserved, the request is accepted, has no effect, and now is unchanged.
- Normalisation trigger: if an accepted TOUCH/FILL makes now+1 == TICK_MAX, the state goes to S_NORM on the next edge.
- S_NORM: one line per cycle, ptr = 1..NUM_LINES.
  - tick[ptr] <= (tick[ptr]==0) ? 0 : max(tick[ptr]>>1, 1).
  - Zero stays zero, so invalid lines remain strictly oldest.
  - On ptr==NUM_LINES: now <= (now>>1)+1, ptr <= 1, state S_IDLE.
- Normalisation duration is exactly NUM_LINES cycles with req_ready=0. Relative order is preserved except that ties may appear; the selector breaks ties itself.
- Arithmetic: unsigned, TICK_WIDTH bits. The counter never wraps because normalisation fires first.
- A request presented while req_ready=0 is ignored; the requester holds valid and idx.

Optional Feature:
LRU_STATS_EN
- Defined: adds outputs stat_hits, stat_fills and stat_norms, each 32 bits. They count accepted TOUCH, accepted FILL and completed S_NORM passes. They are cleared on reset and saturate at all-ones.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package lru_pkg: lru_op_t enum (OP_TOUCH/OP_FILL/OP_INVAL), state_t enum (S_IDLE/S_NORM), and a localparam helper for the index width.
- One sub-module, lru_tick_halve: combinational single-tick normalise function (zero-preserving halve with floor of 1). It is reused by the S_NORM datapath and by the bench's reference model.

Test Plan:
- Reset, then sample: all tick=0, now=1, req_ready=1, normalizing=0.
- TOUCH idx 5, FILL idx 9, TOUCH idx 5 on back-to-back cycles -> tick[5]=3, tick[9]=2, now=4.
- INVAL idx 9 after the above -> tick[9]=0, now=4. Request with req_idx=0 or 33 -> no tick change, now=4.
- TICK_MAX=8, NUM_LINES=4, stamp lines 1..4 then repeat TOUCH idx 1 until the trigger:
  - normalizing=1 and req_ready=0 for exactly 4 cycles.
  - Ticks become halved with floor 1; zero lines stay 0.
  - now=(7>>1)+1=4.
- Hold req_valid with TOUCH idx 2 throughout S_NORM -> accepted only on the first S_IDLE cycle, applied once.
- Assert resetn=0 at the 2nd S_NORM cycle -> next cycle all ticks 0, now=1, S_IDLE. With LRU_STATS_EN defined, stat counters also read 0.
